cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/cpu_alu.sv | 29 ++
 rtl/cpu.sv | 205 ++++++++++++++++++++
 tb/tb_cpu.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and RV32I encoding constants for the multi-cycle cpu.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        Fetch   = 2'd0,
        Execute = 2'd1,
        Load    = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_EQ
    } alu_op_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: arithmetic, logic, shifts and compares; compares return 0/1.
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_SLL:  y = a << b[4:0];
            ALU_SLT:  y = {31'b0, ($signed(a) < $signed(b))};
            ALU_SLTU: y = {31'b0, (a < b)};
            ALU_XOR:  y = a ^ b;
            ALU_SRL:  y = a >> b[4:0];
            ALU_SRA:  y = 32'($signed(a) >>> b[4:0]);
            ALU_OR:   y = a | b;
            ALU_AND:  y = a & b;
            ALU_EQ:   y = {31'b0, (a == b)};
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/cpu.sv
// Multi-cycle RV32I core: Fetch/Execute (+Load) over a single word-addressed bus.
// Define CPU_REGS_RESET_EN to give the register file an asynchronous clear.
module cpu
    import cpu_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    output logic [XLEN-1:0] bus_addr,
    input  logic [XLEN-1:0] bus_data_r,
    output logic [XLEN-1:0] bus_data_w,
    output logic [3:0]      bus_mask_w
);

    state_t          state, state_d;
    logic [XLEN-1:0] inst, inst_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] regs [0:31];

    logic [6:0]      opcode;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      f3;
    logic            f7b5;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] rs1_v, rs2_v, ea, pc_plus4;
    logic [XLEN-1:0] alu_b, alu_y;
    alu_op_t         alu_op;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic            rf_we;
    logic [XLEN-1:0] rf_wd;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign f3     = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign f7b5   = inst[30];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'b0};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    assign rs1_v    = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_v    = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign ea       = rs1_v + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign pc_plus4 = pc + 32'd4;

    // Byte/halfword lane select for loads; the Load cycle recomputes ea from unchanged rs1.
    assign ld_byte = 8'(bus_data_r >> {ea[1:0], 3'b000});
    assign ld_half = ea[1] ? bus_data_r[31:16] : bus_data_r[15:0];

    assign alu_b = (opcode == OPC_OP || opcode == OPC_BRANCH) ? rs2_v : imm_i;

    always_comb begin
        alu_op = ALU_ADD;
        if (opcode == OPC_BRANCH) begin
            case (f3)
                F3_BLT, F3_BGE:   alu_op = ALU_SLT;
                F3_BLTU, F3_BGEU: alu_op = ALU_SLTU;
                default:          alu_op = ALU_EQ;
            endcase
        end else begin
            case (f3)
                F3_ADD:  alu_op = (opcode == OPC_OP && f7b5) ? ALU_SUB : ALU_ADD;
                F3_SLL:  alu_op = ALU_SLL;
                F3_SLT:  alu_op = ALU_SLT;
                F3_SLTU: alu_op = ALU_SLTU;
                F3_XOR:  alu_op = ALU_XOR;
                F3_SR:   alu_op = f7b5 ? ALU_SRA : ALU_SRL;
                F3_OR:   alu_op = ALU_OR;
                F3_AND:  alu_op = ALU_AND;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    cpu_alu u_alu (
        .a  (rs1_v),
        .b  (alu_b),
        .op (alu_op),
        .y  (alu_y)
    );

    always_comb begin
        state_d    = state;
        inst_d     = inst;
        pc_d       = pc;
        rf_we      = 1'b0;
        rf_wd      = '0;
        bus_addr   = {2'b00, pc[31:2]};
        bus_data_w = '0;
        bus_mask_w = 4'b0000;
        case (state)
            Fetch: begin
                inst_d  = bus_data_r;
                state_d = Execute;
            end
            Execute: begin
                state_d = Fetch;
                pc_d    = pc_plus4;
                case (opcode)
                    OPC_LUI: begin
                        rf_we = 1'b1;
                        rf_wd = imm_u;
                    end
                    OPC_AUIPC: begin
                        rf_we = 1'b1;
                        rf_wd = pc + imm_u;
                    end
                    OPC_JAL: begin
                        rf_we = 1'b1;
                        rf_wd = pc_plus4;
                        pc_d  = pc + imm_j;
                    end
                    OPC_JALR: begin
                        rf_we = 1'b1;
                        rf_wd = pc_plus4;
                        pc_d  = {ea[31:1], 1'b0};
                    end
                    OPC_BRANCH: begin
                        // Odd funct3 values invert the compare (BNE/BGE/BGEU).
                        case (f3)
                            F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU:
                                if (alu_y[0] ^ f3[0]) pc_d = pc + imm_b;
                            default: ;
                        endcase
                    end
                    OPC_LOAD: begin
                        bus_addr = {2'b00, ea[31:2]};
                        pc_d     = pc;
                        state_d  = Load;
                    end
                    OPC_STORE: begin
                        bus_addr = {2'b00, ea[31:2]};
                        case (f3)
                            F3_SB: begin
                                bus_data_w = {4{rs2_v[7:0]}};
                                bus_mask_w = 4'b0001 << ea[1:0];
                            end
                            F3_SH: begin
                                bus_data_w = {2{rs2_v[15:0]}};
                                bus_mask_w = 4'b0011 << {ea[1], 1'b0};
                            end
                            F3_SW: begin
                                bus_data_w = rs2_v;
                                bus_mask_w = 4'b1111;
                            end
                            default: ;
                        endcase
                    end
                    OPC_IMM, OPC_OP: begin
                        rf_we = 1'b1;
                        rf_wd = alu_y;
                    end
                    default: ;
                endcase
            end
            Load: begin
                bus_addr = {2'b00, ea[31:2]};
                rf_we    = 1'b1;
                pc_d     = pc_plus4;
                state_d  = Fetch;
                case (f3)
                    F3_LB:   rf_wd = {{24{ld_byte[7]}}, ld_byte};
                    F3_LH:   rf_wd = {{16{ld_half[15]}}, ld_half};
                    F3_LBU:  rf_wd = {24'b0, ld_byte};
                    F3_LHU:  rf_wd = {16'b0, ld_half};
                    default: rf_wd = bus_data_r;
                endcase
            end
            default: state_d = Fetch;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= Fetch;
            pc    <= '0;
            inst  <= NOP_INST;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            inst  <= inst_d;
        end
    end

`ifdef CPU_REGS_RESET_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (rf_we && rd != 5'd0) begin
            regs[rd] <= rf_wd;
        end
    end
`else
    // No reset: x0 is re-zeroed every cycle so probes of regs[0] see 0.
    always_ff @(posedge clock) begin
        regs[0] <= '0;
        if (rf_we && rd != 5'd0) regs[rd] <= rf_wd;
    end
`endif

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: directed programs push expected ECALL checkpoints and stores.
module tb_cpu;
    import cpu_pkg::*;

    logic        clock;
    logic        reset;
    logic [31:0] bus_addr;
    logic [31:0] bus_data_r;
    logic [31:0] bus_data_w;
    logic [3:0]  bus_mask_w;

    cpu dut (
        .clock      (clock),
        .reset      (reset),
        .bus_addr   (bus_addr),
        .bus_data_r (bus_data_r),
        .bus_data_w (bus_data_w),
        .bus_mask_w (bus_mask_w)
    );

    typedef struct {
        logic [31:0] pc;
        int          r;
        logic [31:0] val;
    } chk_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
        logic [31:0] lanes;
    } st_t;

    chk_t        chk_q[$];
    st_t         st_q[$];
    logic [31:0] img [0:127];
    logic [31:0] mem [0:127];
    int          checks;
    int          errors;
    int          pos;
    int          pc_bias;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory samples on the falling edge; reload image while reset is held.
    always @(negedge clock) begin
        if (reset) begin
            for (int i = 0; i < 128; i++) mem[i] = img[i];
        end else begin
            for (int b = 0; b < 4; b++)
                if (bus_mask_w[b]) mem[bus_addr[6:0]][8*b +: 8] = bus_data_w[8*b +: 8];
        end
        bus_data_r <= mem[bus_addr[6:0]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s unexpected event pc=%h", name, dut.pc);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus_mask_w != 4'h0) begin : mon_st
                st_t e;
                if (st_q.size() == 0) unexpected("store");
                else begin
                    e = st_q.pop_front();
                    check("st_addr", bus_addr, e.addr);
                    check("st_mask", {28'b0, bus_mask_w}, {28'b0, e.mask});
                    check("st_data", bus_data_w & e.lanes, e.data & e.lanes);
                end
            end
            if (dut.state == Execute && dut.inst == 32'h0000_0073) begin : mon_chk
                chk_t c;
                if (chk_q.size() == 0) unexpected("ecall");
                else begin
                    c = chk_q.pop_front();
                    check("ecall_pc", dut.pc, c.pc);
                    check($sformatf("x%0d", c.r), dut.regs[c.r], c.val);
                end
            end
        end
    end

    function automatic logic [31:0] enc_i(input int op, input int rd, input int f3, input int rs1,
                                          input logic [31:0] imm);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_s(input int f3, input int rs1, input int rs2,
                                          input logic [31:0] imm);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input int f3, input int rs1, input int rs2,
                                          input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3,
                                          input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
    endfunction

    function automatic logic [31:0] enc_u(input int op, input int rd, input logic [31:0] imm);
        return {imm[19:0], rd[4:0], op[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(input int rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6F};
    endfunction

    task automatic emit(input logic [31:0] w);
        img[pos] = w;
        pos++;
    endtask

    task automatic emit_chk(input int r, input logic [31:0] v);
        chk_t e;
        e.pc  = 32'(pos * 4 + pc_bias);
        e.r   = r;
        e.val = v;
        chk_q.push_back(e);
        emit(32'h0000_0073);
    endtask

    task automatic exp_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                             input logic [31:0] l);
        st_t e;
        e.addr  = a;
        e.mask  = m;
        e.data  = d;
        e.lanes = l;
        st_q.push_back(e);
    endtask

    task automatic begin_prog();
        reset = 1'b1;
        for (int i = 0; i < 128; i++) img[i] = 32'h0000_006F;
        pos     = 0;
        pc_bias = 0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((chk_q.size() != 0 || st_q.size() != 0) && n < 3000) begin
            @(posedge clock);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s timeout pending_chk=%0d pending_st=%0d", name, chk_q.size(),
                     st_q.size());
        end
        repeat (20) @(posedge clock);
    endtask

    task automatic wait_load(input string name);
        bit hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(posedge clock);
            #1;
            if (dut.state == Load) hit = 1'b1;
        end
        check(name, {31'b0, hit}, 32'd1);
    endtask

    task automatic wait_store_exec(input string name);
        bit hit = 1'b0;
        for (int n = 0; n < 200 && !hit; n++) begin
            @(posedge clock);
            #1;
            if (dut.state == Execute && dut.inst[6:0] == 7'h23) hit = 1'b1;
        end
        check(name, {31'b0, hit}, 32'd1);
    endtask

    logic [31:0] w1_orig, w3_orig, auipc_exp;

    initial begin
        checks = 0;
        errors = 0;

        // Reset values while reset is held.
        begin_prog();
        @(posedge clock);
        #1;
        check("rst_state", 32'(dut.state), 32'(Fetch));
        check("rst_pc", dut.pc, 32'h0);
        check("rst_inst", dut.inst, 32'h0000_0013);
        check("rst_mask", {28'b0, bus_mask_w}, 32'h0);
        check("rst_addr", bus_addr, 32'h0);

        // Program 1: ECALL checkpoint and ALU operations.
        emit(32'h0050_0513);
        emit_chk(10, 32'd5);
        emit(enc_i(32'h13, 11, 0, 0, 32'hFFFF_FFFD));
        emit_chk(11, 32'hFFFF_FFFD);
        emit(enc_r(0, 10, 11, 2, 12));
        emit_chk(12, 32'd1);
        emit(enc_r(0, 10, 11, 3, 13));
        emit_chk(13, 32'd0);
        emit(enc_i(32'h13, 14, 5, 11, 32'h401));
        emit_chk(14, 32'hFFFF_FFFE);
        emit(enc_i(32'h13, 15, 5, 11, 32'd28));
        emit_chk(15, 32'h0000_000F);
        emit(enc_r(32'h20, 11, 10, 0, 16));
        emit_chk(16, 32'd8);
        emit(enc_u(32'h37, 17, 32'h12345));
        emit_chk(17, 32'h1234_5000);
        emit(enc_i(32'h13, 20, 7, 11, 32'h0F0));
        emit_chk(20, 32'h0000_00F0);
        emit(enc_r(0, 17, 10, 6, 21));
        emit_chk(21, 32'h1234_5005);
        emit(enc_r(0, 10, 10, 1, 22));
        emit_chk(22, 32'h0000_00A0);
        emit(enc_r(0, 11, 11, 0, 23));
        emit_chk(23, 32'hFFFF_FFFA);
        auipc_exp = 32'(pos * 4) + 32'h1000;
        emit(enc_u(32'h17, 18, 32'h1));
        emit_chk(18, auipc_exp);
        release_reset();
        wait_idle("prog_alu");

        // Program 2: stores with lane masks, loads with sign/zero extension.
        begin_prog();
        emit(enc_u(32'h37, 5, 32'hDEADC));
        w1_orig = enc_i(32'h13, 5, 0, 5, 32'hFFFF_FEEF);
        emit(w1_orig);
        emit(enc_s(2, 0, 5, 32'd8));
        exp_store(32'd2, 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        w3_orig = enc_i(32'h03, 6, 0, 0, 32'd11);
        emit(w3_orig);
        emit_chk(6, 32'hFFFF_FFDE);
        emit(enc_i(32'h03, 7, 4, 0, 32'd11));
        emit_chk(7, 32'h0000_00DE);
        emit(enc_i(32'h03, 8, 1, 0, 32'd10));
        emit_chk(8, 32'hFFFF_DEAD);
        emit(enc_i(32'h03, 9, 5, 0, 32'd9));
        emit_chk(9, 32'h0000_BEEF);
        emit(enc_i(32'h03, 11, 2, 0, 32'd11));
        emit_chk(11, 32'hDEAD_BEEF);
        emit(enc_i(32'h13, 12, 0, 0, 32'h12));
        emit(enc_s(0, 0, 12, 32'd5));
        exp_store(32'd1, 4'b0010, 32'h0000_1200, 32'h0000_FF00);
        emit(enc_i(32'h03, 13, 2, 0, 32'd4));
        emit_chk(13, (w1_orig & 32'hFFFF_00FF) | 32'h0000_1200);
        emit(enc_s(1, 0, 5, 32'd14));
        exp_store(32'd3, 4'b1100, 32'hBEEF_0000, 32'hFFFF_0000);
        emit(enc_i(32'h03, 14, 2, 0, 32'd12));
        emit_chk(14, (w3_orig & 32'h0000_FFFF) | 32'hBEEF_0000);
        release_reset();
        wait_idle("prog_mem");

        // Program 3: branches, JAL, JALR to a misaligned target, x0 writes.
        begin_prog();
        emit(enc_i(32'h13, 1, 0, 0, 32'd0));
        emit(enc_i(32'h13, 3, 0, 0, 32'd2));
        emit(enc_i(32'h13, 1, 0, 1, 32'd1));
        emit_chk(1, 32'd1);
        begin : second_pass
            chk_t e;
            e.pc  = 32'h0C;
            e.r   = 1;
            e.val = 32'd2;
            chk_q.push_back(e);
        end
        emit(enc_b(1, 1, 3, 32'hFFFF_FFF8));
        emit_chk(1, 32'd2);
        emit(enc_j(5, 32'd8));
        emit(32'h0000_0073);
        emit_chk(5, 32'h0000_001C);
        emit(enc_i(32'h13, 2, 0, 0, 32'h100));
        emit(enc_i(32'h67, 1, 0, 2, 32'd7));
        pos     = 32'h41;
        pc_bias = 2;
        emit_chk(1, 32'h0000_002C);
        emit(enc_r(0, 1, 1, 0, 0));
        emit_chk(0, 32'd0);
        emit(enc_i(32'h13, 4, 0, 0, 32'hFFFF_FFFF));
        emit(enc_b(4, 4, 0, 32'd8));
        emit(32'h0000_0073);
        emit(enc_b(6, 4, 0, 32'd8));
        emit_chk(4, 32'hFFFF_FFFF);
        release_reset();
        wait_idle("prog_ctl");

        // Program 4: reset asserted during Load and during a store cycle.
        begin_prog();
        emit(enc_i(32'h13, 6, 0, 0, 32'h55));
        emit_chk(6, 32'h55);
        emit(enc_i(32'h03, 6, 2, 0, 32'd0));
        emit(enc_s(2, 0, 6, 32'h40));
        release_reset();
        wait_load("reach_load");
        #2 reset = 1'b1;
        #1;
        check("ld_rst_state", 32'(dut.state), 32'(Fetch));
        check("ld_rst_pc", dut.pc, 32'h0);
        check("ld_rst_x6", dut.regs[6], 32'h55);
        check("ld_rst_mask", {28'b0, bus_mask_w}, 32'h0);
        begin : restart_chk
            chk_t e;
            e.pc  = 32'h4;
            e.r   = 6;
            e.val = 32'h55;
            chk_q.push_back(e);
        end
        release_reset();
        wait_store_exec("reach_store");
        check("st_pre_mask", {28'b0, bus_mask_w}, 32'hF);
        reset = 1'b1;
        #1;
        check("st_rst_mask", {28'b0, bus_mask_w}, 32'h0);
        check("st_rst_pc", dut.pc, 32'h0);
        check("rst_chk_q", 32'(chk_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
